// File: rtl/cmd_resp_bridge.sv
// cmd_resp_bridge
// Host-facing end of the 16-bit command / 8-bit response protocol.
// Assembles two UART rx bytes (high byte first) into cmd and holds cmd_rdy
// until cmd_cfg ends processing by asserting clr_cmd_rdy. Response bytes
// pushed by cmd_cfg are queued in a small FIFO and handed to the UART tx.
//
// Optional feature macro: CMD_BYTE_TIMEOUT_EN
//   defined   : a partial command (high byte only) is discarded after
//               TIMEOUT_CYCLES clk cycles without a low byte; rx_timeout pulses
//   undefined : RX_LOW waits indefinitely; rx_timeout tied 0
//
// Ports:
//   clk          system clock
//   clr_cmd_rdy  asynchronous active-high reset (end of command processing)
//   rx_rdy       UART rx byte valid (level)      rx_data   UART rx byte
//   clr_rx_rdy   one-cycle rx byte acknowledge
//   cmd          assembled command               cmd_rdy   command valid
//   resp         response byte                   send_resp response push strobe
//   resp_sent    one-cycle pulse per transmitted byte
//   trmt         one-cycle UART tx start         tx_data   byte to transmit
//   tx_done      UART tx finished current byte
//   resp_ovf     sticky: a response push was dropped
//   rx_timeout   one-cycle pulse: partial command discarded
module cmd_resp_bridge #(
    parameter int unsigned RESP_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        clr_cmd_rdy,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_ovf,
    output logic        rx_timeout
);

    localparam int unsigned AW = $clog2(RESP_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    localparam logic [1:0] RX_HIGH = 2'd0;
    localparam logic [1:0] RX_LOW  = 2'd1;
    localparam logic [1:0] RX_HOLD = 2'd2;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_BUSY = 1'b1;

    // Elaboration-time parameter sanity check
    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cmd_resp_bridge: RESP_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [1:0]  rx_state, rx_state_n;
    logic [15:0] cmd_n;
    logic        cmd_rdy_n;
    logic        clr_rx_rdy_n;
    logic        capture;

`ifdef CMD_BYTE_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             rx_timeout_n;
`endif

    // The clr_rx_rdy term blocks a second capture while the UART is still
    // dropping rx_rdy in response to our acknowledge.
    assign capture = rx_rdy && !clr_rx_rdy && (rx_state != RX_HOLD);

    // Receive next-state and output logic
    always_comb begin
        rx_state_n   = rx_state;
        cmd_n        = cmd;
        cmd_rdy_n    = cmd_rdy;
        clr_rx_rdy_n = 1'b0;
`ifdef CMD_BYTE_TIMEOUT_EN
        tmo_cnt_n    = tmo_cnt;
        rx_timeout_n = 1'b0;
`endif
        case (rx_state)
            RX_HIGH: begin
                if (capture) begin
                    cmd_n[15:8]  = rx_data;
                    clr_rx_rdy_n = 1'b1;
                    rx_state_n   = RX_LOW;
`ifdef CMD_BYTE_TIMEOUT_EN
                    tmo_cnt_n    = '0;
`endif
                end
            end
            RX_LOW: begin
                if (capture) begin
                    cmd_n[7:0]   = rx_data;
                    cmd_rdy_n    = 1'b1;
                    clr_rx_rdy_n = 1'b1;
                    rx_state_n   = RX_HOLD;
`ifdef CMD_BYTE_TIMEOUT_EN
                end else if (tmo_cnt == TMO_LAST) begin
                    cmd_n[15:8]  = 8'h00;
                    rx_timeout_n = 1'b1;
                    rx_state_n   = RX_HIGH;
                end else begin
                    tmo_cnt_n    = tmo_cnt + TMO_W'(1);
`endif
                end
            end
            RX_HOLD: begin
                // Hold command until cmd_cfg resets us; bytes wait in the UART.
            end
            default: begin
                rx_state_n = RX_HIGH;
            end
        endcase
    end

    // Receive state and output registers
    always_ff @(posedge clk or posedge clr_cmd_rdy) begin
        if (clr_cmd_rdy) begin
            rx_state   <= RX_HIGH;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            cmd        <= cmd_n;
            cmd_rdy    <= cmd_rdy_n;
            clr_rx_rdy <= clr_rx_rdy_n;
        end
    end

`ifdef CMD_BYTE_TIMEOUT_EN
    // Partial-command timeout registers
    always_ff @(posedge clk or posedge clr_cmd_rdy) begin
        if (clr_cmd_rdy) begin
            tmo_cnt    <= '0;
            rx_timeout <= 1'b0;
        end else begin
            tmo_cnt    <= tmo_cnt_n;
            rx_timeout <= rx_timeout_n;
        end
    end
`else
    assign rx_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response FIFO and transmit path
    // ------------------------------------------------------------------
    logic [7:0]    mem [RESP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          push, pop;
    logic          resp_ovf_n;

    logic [0:0]    tx_state, tx_state_n;
    logic          trmt_n;
    logic          resp_sent_n;
    logic [7:0]    tx_data_n;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = (tx_state == TX_IDLE) && (count != '0);
    assign push = send_resp && ((count < DEPTH_C) || pop);

    // FIFO occupancy and overflow flag
    always_comb begin
        count_n    = count;
        resp_ovf_n = resp_ovf;
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        if (send_resp && !push) begin
            resp_ovf_n = 1'b1;
        end
    end

    // Transmit next-state and output logic
    always_comb begin
        tx_state_n  = tx_state;
        trmt_n      = 1'b0;
        resp_sent_n = 1'b0;
        tx_data_n   = tx_data;
        case (tx_state)
            TX_IDLE: begin
                if (pop) begin
                    tx_data_n  = mem[rd_ptr];
                    trmt_n     = 1'b1;
                    tx_state_n = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_n = 1'b1;
                    tx_state_n  = TX_IDLE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

    // Transmit state, FIFO pointers and output registers
    always_ff @(posedge clk or posedge clr_cmd_rdy) begin
        if (clr_cmd_rdy) begin
            tx_state  <= TX_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            resp_ovf  <= 1'b0;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_state  <= tx_state_n;
            count     <= count_n;
            resp_ovf  <= resp_ovf_n;
            trmt      <= trmt_n;
            resp_sent <= resp_sent_n;
            tx_data   <= tx_data_n;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= resp;
        end
    end

endmodule

// File: tb/tb_cmd_resp_bridge.sv
// Directed self-checking bench for cmd_resp_bridge.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cmd_resp_bridge;

    logic        clk;
    logic        clr_cmd_rdy;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_ovf;
    logic        rx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_resp_bridge #(
        .RESP_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .clr_cmd_rdy (clr_cmd_rdy),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_ovf    (resp_ovf),
        .rx_timeout  (rx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        send_resp   = 1'b0;
        tx_done     = 1'b0;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (cmd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h expected 0000", cmd);
        end
        n_checks++;
        if ({cmd_rdy, clr_rx_rdy, trmt, resp_sent, resp_ovf, rx_timeout} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {cmd_rdy, clr_rx_rdy, trmt, resp_sent, resp_ovf, rx_timeout});
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_rx_cmd();
        int pulses;
        rx_data = 8'h4B;
        rx_rdy  = 1'b1;
        tick();
        n_checks++;
        if ({clr_rx_rdy, cmd[15:8], cmd_rdy} !== {1'b1, 8'h4B, 1'b0}) begin
            n_fail++;
            $display("FAIL rx_high: got clr=%b hi=%h rdy=%b expected clr=1 hi=4b rdy=0",
                     clr_rx_rdy, cmd[15:8], cmd_rdy);
        end
        rx_rdy = 1'b0;
        tick();
        n_checks++;
        if (clr_rx_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_ack_pulse: got clr=%b expected 0", clr_rx_rdy);
        end
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        tick();
        n_checks++;
        if ({clr_rx_rdy, cmd, cmd_rdy} !== {1'b1, 16'h4B55, 1'b1}) begin
            n_fail++;
            $display("FAIL rx_low: got clr=%b cmd=%h rdy=%b expected clr=1 cmd=4b55 rdy=1",
                     clr_rx_rdy, cmd, cmd_rdy);
        end
        rx_rdy = 1'b0;
        tick();
        // Third byte must be back-pressured while the command is held
        rx_data = 8'h11;
        rx_rdy  = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_rx_rdy) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || cmd !== 16'h4B55 || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_hold: got acks=%0d cmd=%h rdy=%b expected acks=0 cmd=4b55 rdy=1",
                     pulses, cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        n_checks++;
        if ({cmd, cmd_rdy} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rx_async_clear: got cmd=%h rdy=%b expected cmd=0000 rdy=0", cmd, cmd_rdy);
        end
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        tick();
        n_checks++;
        if ({clr_rx_rdy, cmd, cmd_rdy} !== {1'b1, 16'h1100, 1'b0}) begin
            n_fail++;
            $display("FAIL rx_new_high: got clr=%b cmd=%h rdy=%b expected clr=1 cmd=1100 rdy=0",
                     clr_rx_rdy, cmd, cmd_rdy);
        end
        rx_rdy = 1'b0;
        tick();
    endtask

    task automatic test_resp_single();
        int bad;
        reset_dut();
        resp      = 8'hA5;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        n_checks++;
        if (trmt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency1: got trmt=%b expected 0", trmt);
        end
        tick();
        n_checks++;
        if ({trmt, tx_data} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_trmt: got trmt=%b data=%h expected trmt=1 data=a5", trmt, tx_data);
        end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (trmt || resp_sent || tx_data !== 8'hA5) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL single_busy: got %0d bad cycles expected 0", bad);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++;
        if (resp_sent !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sent: got resp_sent=%b expected 1", resp_sent);
        end
        tick();
        n_checks++;
        if ({resp_sent, trmt} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after: got sent=%b trmt=%b expected 0 0", resp_sent, trmt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            resp      = 8'(i);
            send_resp = 1'b1;
            tick();
            if (i == 2) begin
                n_checks++;
                if ({trmt, tx_data} !== {1'b1, 8'h01}) begin
                    n_fail++;
                    $display("FAIL b2b_first: got trmt=%b data=%h expected trmt=1 data=01", trmt, tx_data);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (resp_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_no_ovf: got resp_ovf=%b expected 0", resp_ovf);
                end
            end
        end
        send_resp = 1'b0;
        n_checks++;
        if (resp_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ovf: got resp_ovf=%b expected 1", resp_ovf);
        end
        for (int k = 2; k <= 5; k++) begin
            exp     = 8'(k);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            n_checks++;
            if (resp_sent !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_sent%0d: got resp_sent=%b expected 1", k - 1, resp_sent);
            end
            tick();
            n_checks++;
            if ({trmt, tx_data} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL b2b_order%0d: got trmt=%b data=%h expected trmt=1 data=%h",
                         k, trmt, tx_data, exp);
            end
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        n_checks++;
        if ({trmt, resp_ovf} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_drained: got trmt=%b ovf=%b expected trmt=0 ovf=1", trmt, resp_ovf);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            resp      = 8'hA0 + 8'(i);
            send_resp = 1'b1;
            tick();
        end
        send_resp = 1'b0;
        // Finish A0 while A1..A4 fill the FIFO; push coincides with next pop
        tx_done = 1'b1;
        tick();
        tx_done   = 1'b0;
        resp      = 8'hA5;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        n_checks++;
        if ({trmt, tx_data, resp_ovf} !== {1'b1, 8'hA1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pop: got trmt=%b data=%h ovf=%b expected trmt=1 data=a1 ovf=0",
                     trmt, tx_data, resp_ovf);
        end
        for (int k = 0; k < 4; k++) begin
            exp     = 8'hA2 + 8'(k);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            tick();
            n_checks++;
            if ({trmt, tx_data, resp_ovf} !== {1'b1, exp, 1'b0}) begin
                n_fail++;
                $display("FAIL full_drain%0d: got trmt=%b data=%h ovf=%b expected trmt=1 data=%h ovf=0",
                         k, trmt, tx_data, resp_ovf, exp);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        int bad;
        reset_dut();
        resp      = 8'hB1;
        send_resp = 1'b1;
        tick();
        resp = 8'hB2;
        tick();
        send_resp = 1'b0;
        n_checks++;
        if ({trmt, tx_data} !== {1'b1, 8'hB1}) begin
            n_fail++;
            $display("FAIL midtx_start: got trmt=%b data=%h expected trmt=1 data=b1", trmt, tx_data);
        end
        tick();
        clr_cmd_rdy = 1'b1;
        #1;
        n_checks++;
        if ({trmt, resp_sent, tx_data} !== {1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midtx_clear: got trmt=%b sent=%b data=%h expected 0 0 00",
                     trmt, resp_sent, tx_data);
        end
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (trmt || resp_sent) bad++;
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (trmt || resp_sent) bad++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (trmt || resp_sent) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midtx_abandon: got %0d trmt/resp_sent cycles expected 0", bad);
        end
    endtask

`ifdef CMD_BYTE_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit seen;
        reset_dut();
        rx_data = 8'h81;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy = 1'b0;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 200) begin
            tick();
            cyc++;
            if (rx_timeout) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cyc !== 100 || cmd !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_pulse: got seen=%b cycle=%0d cmd=%h expected seen=1 cycle=100 cmd=0000",
                     seen, cyc, cmd);
        end
        tick();
        rx_data = 8'h0B;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy = 1'b0;
        tick();
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy = 1'b0;
        n_checks++;
        if ({cmd, cmd_rdy, rx_timeout} !== {16'h0B55, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_recover: got cmd=%h rdy=%b tmo=%b expected cmd=0b55 rdy=1 tmo=0",
                     cmd, cmd_rdy, rx_timeout);
        end
    endtask
`endif

    initial begin
        clr_cmd_rdy = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        resp        = 8'h00;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
        test_reset();
        test_rx_cmd();
        test_resp_single();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_tx();
`ifdef CMD_BYTE_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
